seq_divider: RTL and testbench

Sequential unsigned restoring divider. It is the inverse-direction companion to the array and shift-add multipliers in the Multipliers area. It produces one quotient bit per clock, using a ripple-borrow subtractor built from the existing full-adder cells. It has a start/ready request handshake and a valid/ack result handshake, so it can sit behind a multiplier in the same datapath or be driven directly by a testbench.

---
 rtl/div_pkg.sv | 13 +
 rtl/ripple_sub.sv | 37 +++
 rtl/seq_divider.sv | 122 ++++++++++++
 tb/tb_seq_divider.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared constants for the sequential restoring divider: FSM state encoding
// and the default operand width.
package div_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage : div_pkg

// File: rtl/ripple_sub.sv
// N-bit ripple-borrow subtractor a - b, built as a + ~b + 1 on a chain of
// full-adder cells; no_borrow is the final carry-out (1 when a >= b).
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule : full_adder

module ripple_sub #(
  parameter int N = 9
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         no_borrow
);
  logic [N:0] carry;

  assign carry[0] = 1'b1;

  for (genvar i = 0; i < N; i++) begin : g_fa
    full_adder u_fa (
      .a   (a[i]),
      .b   (~b[i]),
      .cin (carry[i]),
      .sum (diff[i]),
      .cout(carry[i+1])
    );
  end

  assign no_borrow = carry[N];
endmodule : ripple_sub

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, start/ready
// request handshake and valid/ack result handshake.
//
// Handshakes: a request is accepted on a rising edge where start=1 and ready=1;
// a result is consumed on a rising edge where valid=1 and ack=1. Outputs are
// stable for as long as valid=1 and ack=0.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             valid,
  input  logic             ack,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);

  div_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic             dz_q, dz_d;

  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   trial;
  logic             no_borrow;
  logic             unused_rem_msb;

  // Shift {rem, quo} left by one: the quotient MSB moves into the remainder.
  assign rem_shift      = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
  assign unused_rem_msb = rem_q[WIDTH];

  ripple_sub #(
    .N(WIDTH + 1)
  ) u_sub (
    .a        (rem_shift),
    .b        ({1'b0, div_q}),
    .diff     (trial),
    .no_borrow(no_borrow)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    div_d   = div_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          div_d = divisor;
          if (divisor == '0) begin
            quo_d   = '1;
            rem_d   = {1'b0, dividend};
            dz_d    = 1'b1;
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            quo_d   = dividend;
            rem_d   = '0;
            dz_d    = 1'b0;
            cnt_d   = CW'(WIDTH);
            state_d = RUN;
          end
        end
      end
      RUN: begin
        quo_d = {quo_q[WIDTH-2:0], no_borrow};
        rem_d = no_borrow ? trial : rem_shift;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (ack) begin
          dz_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      div_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      dz_q    <= dz_d;
    end
  end

  assign ready       = (state_q == IDLE);
  assign valid       = (state_q == DONE);
  assign quotient    = quo_q;
  assign remainder   = rem_q[WIDTH-1:0];
  assign div_by_zero = dz_q;
  assign dbg_state   = state_q;

endmodule : seq_divider

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed vector table, handshake and
// reset corner cases, and a randomized sweep against an arithmetic model.
module tb_seq_divider;

  localparam int W = 8;
  localparam int LAT_BUDGET = 50;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         ack = 1'b0;
  logic         ready, valid, div_by_zero;
  logic [W-1:0] quotient, remainder;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [W-1:0] n;
    logic [W-1:0] d;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } vec_t;

  vec_t vecs[$];

  seq_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .ready      (ready),
    .valid      (valid),
    .ack        (ack),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Accept one request, then wait (bounded) for valid. Optionally pokes start
  // with other operands during RUN to show it is ignored.
  task automatic run_op(input logic [W-1:0] n, input logic [W-1:0] d, input bit intrude,
                        output logic [W-1:0] q, output logic [W-1:0] r,
                        output logic dz, output int lat);
    check("ready_before_start", {31'b0, ready}, 32'd1);
    start    = 1'b1;
    dividend = n;
    divisor  = d;
    @(negedge clk);
    start = 1'b0;
    check("ready_after_accept", {31'b0, ready}, 32'd0);
    // operands are sampled only on the accept edge
    dividend = W'($urandom_range(0, 255));
    divisor  = W'($urandom_range(0, 255));
    lat = 0;
    while (!valid && lat < LAT_BUDGET) begin
      if (intrude && lat == 2) begin
        start    = 1'b1;
        dividend = ~n;
        divisor  = d + 8'd3;
      end else begin
        start = 1'b0;
      end
      if (lat < 7 && d != 0) check("valid_early", {31'b0, valid}, 32'd0);
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    q  = quotient;
    r  = remainder;
    dz = div_by_zero;
  endtask

  // Hold ack low for hold cycles checking stability, then pulse ack.
  task automatic finish_op(input logic [W-1:0] q, input logic [W-1:0] r,
                           input logic dz, input int hold);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", {31'b0, valid}, 32'd1);
      check("hold_q", {24'b0, quotient}, {24'b0, q});
      check("hold_r", {24'b0, remainder}, {24'b0, r});
      check("hold_dz", {31'b0, div_by_zero}, {31'b0, dz});
    end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check("ack_ready", {31'b0, ready}, 32'd1);
    check("ack_valid", {31'b0, valid}, 32'd0);
    check("ack_dz_clear", {31'b0, div_by_zero}, 32'd0);
    check("ack_q_kept", {24'b0, quotient}, {24'b0, q});
    check("ack_r_kept", {24'b0, remainder}, {24'b0, r});
  endtask

  initial begin
    logic [W-1:0] q, r, n, d, exp_q, exp_r;
    logic         dz;
    int           lat;

    vecs.push_back('{n: 8'd100, d: 8'd7,   q: 8'd14,  r: 8'd2,  dz: 1'b0});
    vecs.push_back('{n: 8'd255, d: 8'd1,   q: 8'd255, r: 8'd0,  dz: 1'b0});
    vecs.push_back('{n: 8'd5,   d: 8'd9,   q: 8'd0,   r: 8'd5,  dz: 1'b0});
    vecs.push_back('{n: 8'd255, d: 8'd255, q: 8'd1,   r: 8'd0,  dz: 1'b0});
    vecs.push_back('{n: 8'd0,   d: 8'd3,   q: 8'd0,   r: 8'd0,  dz: 1'b0});
    vecs.push_back('{n: 8'd77,  d: 8'd0,   q: 8'hFF,  r: 8'd77, dz: 1'b1});
    vecs.push_back('{n: 8'd200, d: 8'd13,  q: 8'd15,  r: 8'd5,  dz: 1'b0});

    repeat (3) @(negedge clk);
    check("rst_ready", {31'b0, ready}, 32'd1);
    check("rst_valid", {31'b0, valid}, 32'd0);
    check("rst_q", {24'b0, quotient}, 32'd0);
    check("rst_r", {24'b0, remainder}, 32'd0);
    check("rst_dz", {31'b0, div_by_zero}, 32'd0);
    check("rst_state", {30'b0, dbg_state}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // directed vector table
    foreach (vecs[i]) begin
      run_op(vecs[i].n, vecs[i].d, 1'b0, q, r, dz, lat);
      check("vec_latency", lat, (vecs[i].d == 0) ? 32'd0 : 32'd8);
      check("vec_q", {24'b0, q}, {24'b0, vecs[i].q});
      check("vec_r", {24'b0, r}, {24'b0, vecs[i].r});
      check("vec_dz", {31'b0, dz}, {31'b0, vecs[i].dz});
      finish_op(q, r, dz, 1);
    end

    // long hold in DONE with start poked during RUN
    run_op(8'd100, 8'd7, 1'b1, q, r, dz, lat);
    check("intrude_latency", lat, 32'd8);
    check("intrude_q", {24'b0, q}, 32'd14);
    check("intrude_r", {24'b0, r}, 32'd2);
    finish_op(q, r, dz, 20);

    // reset in the middle of 200/13, after four iterations
    start = 1'b1; dividend = 8'd200; divisor = 8'd13;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_state", {30'b0, dbg_state}, 32'd0);
    check("midrst_ready", {31'b0, ready}, 32'd1);
    check("midrst_valid", {31'b0, valid}, 32'd0);
    check("midrst_q", {24'b0, quotient}, 32'd0);
    check("midrst_r", {24'b0, remainder}, 32'd0);
    run_op(8'd200, 8'd13, 1'b0, q, r, dz, lat);
    check("post_rst_latency", lat, 32'd8);
    check("post_rst_q", {24'b0, q}, 32'd15);
    check("post_rst_r", {24'b0, r}, 32'd5);
    finish_op(q, r, dz, 0);

    // randomized back-to-back sweep against the arithmetic reference
    for (int k = 0; k < 1000; k++) begin
      n = W'($urandom_range(0, 255));
      d = W'($urandom_range(1, 255));
      exp_q = n / d;
      exp_r = n % d;
      run_op(n, d, 1'b0, q, r, dz, lat);
      check("rnd_latency", lat, 32'd8);
      check("rnd_q", {24'b0, q}, {24'b0, exp_q});
      check("rnd_r", {24'b0, r}, {24'b0, exp_r});
      check("rnd_identity", (32'(q) * 32'(d)) + 32'(r), 32'(n));
      check("rnd_r_lt_d", {31'b0, (r < d)}, 32'd1);
      check("rnd_dz", {31'b0, dz}, 32'd0);
      finish_op(q, r, dz, $urandom_range(0, 4));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_seq_divider
